// File: rtl/regfile_dump_ctrl.sv
// regfile_dump_ctrl
// Debug-side sequencer that takes over register-file read port 1 while the
// pipeline is halted, walks registers 0 .. 2**NB_ADDR-1, and streams each
// word to the UART transmitter as bytes, least-significant byte first.
//
// Ports:
//   clk            system clock, rising edge
//   i_rst          synchronous reset, active-high
//   i_start        dump request (honoured in IDLE only, and only if i_halted)
//   i_abort        cancel a dump in progress
//   i_halted       pipeline halted qualifier for i_start
//   o_rf_sel       1 = this block drives register-file read address 1
//   o_rf_rd_addr   register-file read address 1
//   i_rf_rd_data   register-file read data 1 (valid one cycle after address)
//   o_tx_valid     byte available for the transmitter
//   o_tx_data      byte to transmit
//   i_tx_ready     transmitter accepts the byte
//   o_busy         dump in progress
//   o_done         one-cycle pulse after the last byte is accepted
module regfile_dump_ctrl #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 5,
    parameter int NB_BYTE = 8
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic               i_abort,
    input  logic               i_halted,
    output logic               o_rf_sel,
    output logic [NB_ADDR-1:0] o_rf_rd_addr,
    input  logic [NB_DATA-1:0] i_rf_rd_data,
    output logic               o_tx_valid,
    output logic [NB_BYTE-1:0] o_tx_data,
    input  logic               i_tx_ready,
    output logic               o_busy,
    output logic               o_done
);

    localparam int NBYTES  = NB_DATA / NB_BYTE;
    // Keep the byte index at least one bit wide for single-byte words.
    localparam int NB_BIDX = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [NB_BIDX-1:0] LAST_BYTE = NB_BIDX'(NBYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_LATCH,
        S_SEND,
        S_DONE
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [NB_ADDR-1:0]   r_reg_idx;
    logic [NB_ADDR-1:0]   w_reg_idx_nxt;
    logic [NB_BIDX-1:0]   r_byte_idx;
    logic [NB_BIDX-1:0]   w_byte_idx_nxt;
    logic [NB_DATA-1:0]   r_word;
    logic [NB_DATA-1:0]   w_word_nxt;
    logic [NBYTES-1:0][NB_BYTE-1:0] w_bytes;
    logic                 w_sel;

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_reg_idx  <= '0;
            r_byte_idx <= '0;
            r_word     <= '0;
        end else begin
            r_state    <= w_next;
            r_reg_idx  <= w_reg_idx_nxt;
            r_byte_idx <= w_byte_idx_nxt;
            r_word     <= w_word_nxt;
        end
    end

    always_comb begin
        w_next         = r_state;
        w_reg_idx_nxt  = r_reg_idx;
        w_byte_idx_nxt = r_byte_idx;
        w_word_nxt     = r_word;
        case (r_state)
            S_IDLE: begin
                if (i_start && i_halted) begin
                    w_reg_idx_nxt = '0;
                    w_next        = S_READ;
                end
            end
            S_READ:  w_next = S_LATCH;
            S_LATCH: begin
                // Read data is registered inside the register file, so it
                // is valid here, one cycle after the address was driven.
                w_word_nxt     = i_rf_rd_data;
                w_byte_idx_nxt = '0;
                w_next         = S_SEND;
            end
            S_SEND: begin
                if (i_tx_ready) begin
                    if (r_byte_idx != LAST_BYTE) begin
                        w_byte_idx_nxt = r_byte_idx + 1'b1;
                    end else if (&r_reg_idx) begin
                        // Terminal check on all-ones: reg_idx never wraps.
                        w_next = S_DONE;
                    end else begin
                        w_reg_idx_nxt = r_reg_idx + 1'b1;
                        w_next        = S_READ;
                    end
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        // Abort overrides every transition but is meaningless in IDLE.
        if (i_abort && (r_state != S_IDLE)) begin
            w_next = S_IDLE;
        end
    end

    assign w_bytes      = r_word;
    assign w_sel        = (r_state == S_READ) || (r_state == S_LATCH) || (r_state == S_SEND);
    assign o_rf_sel     = w_sel;
    assign o_rf_rd_addr = w_sel ? r_reg_idx : '0;
    assign o_tx_valid   = (r_state == S_SEND);
    assign o_tx_data    = (r_state == S_SEND) ? w_bytes[r_byte_idx] : '0;
    assign o_busy       = (r_state != S_IDLE);
    assign o_done       = (r_state == S_DONE);

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// Self-checking bench for regfile_dump_ctrl: a register-file model with a
// registered read port, a byte-stream monitor, and an expected stream built
// directly from the register contents (LSB-first bytes of r[0]..r[31]).
module tb_regfile_dump_ctrl;

    localparam int NB_DATA = 32;
    localparam int NB_ADDR = 5;
    localparam int NB_BYTE = 8;
    localparam int NREG    = 1 << NB_ADDR;
    localparam int NBYTES  = NB_DATA / NB_BYTE;

    logic               clk = 1'b0;
    logic               i_rst = 1'b1;
    logic               i_start = 1'b0;
    logic               i_abort = 1'b0;
    logic               i_halted = 1'b1;
    logic               o_rf_sel;
    logic [NB_ADDR-1:0] o_rf_rd_addr;
    logic [NB_DATA-1:0] i_rf_rd_data = '0;
    logic               o_tx_valid;
    logic [NB_BYTE-1:0] o_tx_data;
    logic               i_tx_ready = 1'b1;
    logic               o_busy;
    logic               o_done;

    regfile_dump_ctrl #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR), .NB_BYTE(NB_BYTE)) dut (
        .clk          (clk),
        .i_rst        (i_rst),
        .i_start      (i_start),
        .i_abort      (i_abort),
        .i_halted     (i_halted),
        .o_rf_sel     (o_rf_sel),
        .o_rf_rd_addr (o_rf_rd_addr),
        .i_rf_rd_data (i_rf_rd_data),
        .o_tx_valid   (o_tx_valid),
        .o_tx_data    (o_tx_data),
        .i_tx_ready   (i_tx_ready),
        .o_busy       (o_busy),
        .o_done       (o_done)
    );

    always #5 clk = ~clk;

    // Register file with registered read port 1.
    logic [NB_DATA-1:0] rf [NREG];
    always @(posedge clk) i_rf_rd_data <= rf[o_rf_rd_addr];

    int n_assert = 0;
    int n_fail   = 0;
    bit rnd_ready = 1'b0;

    // Monitor state
    int                 cyc = 0;
    logic [NB_BYTE-1:0] got_q[$];
    int                 addr_q[$];
    int                 rdcyc_q[$];
    int                 done_cnt = 0;
    int                 done_cyc = 0;
    int                 stall_err = 0;
    int                 sel_err = 0;
    bit                 prev_rl = 1'b0;
    bit                 prev_v = 1'b0;
    bit                 prev_r = 1'b0;
    bit                 prev_ab = 1'b0;
    logic [NB_BYTE-1:0] prev_d = '0;

    always @(negedge clk) begin
        bit rl;
        cyc++;
        rl = o_rf_sel && !o_tx_valid;   // READ or LATCH; READ is the first of the pair
        if (rl && !prev_rl) begin
            addr_q.push_back(int'(o_rf_rd_addr));
            rdcyc_q.push_back(cyc);
        end
        prev_rl = rl;
        if (o_tx_valid && i_tx_ready) got_q.push_back(o_tx_data);
        if (o_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (prev_v && !prev_r && !prev_ab && !(o_tx_valid && o_tx_data == prev_d)) stall_err++;
        if (o_rf_sel && (!o_busy || o_done)) sel_err++;
        if (!o_rf_sel && o_rf_rd_addr != '0) sel_err++;
        prev_v  = o_tx_valid;
        prev_r  = i_tx_ready;
        prev_d  = o_tx_data;
        prev_ab = i_abort || i_rst;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        i_tx_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " rf_sel"}, 64'(o_rf_sel), 0);
        chk({tag, " rd_addr"}, 64'(o_rf_rd_addr), 0);
        chk({tag, " tx_valid"}, 64'(o_tx_valid), 0);
        chk({tag, " tx_data"}, 64'(o_tx_data), 0);
        chk({tag, " busy"}, 64'(o_busy), 0);
        chk({tag, " done"}, 64'(o_done), 0);
    endtask

    // Start a dump, wait for it, and compare the stream against the bytes
    // of rf[] sent LSB first, register 0 upward.
    task automatic do_dump(input string tag, input bit extra_start, input bit chk_time);
        int d0;
        int nbad;
        int first_bad;
        logic [NB_BYTE-1:0] exp_q[$];
        got_q.delete();
        addr_q.delete();
        rdcyc_q.delete();
        d0 = done_cnt;
        i_halted = 1'b1;
        i_start  = 1'b1;
        tick();
        i_start  = 1'b0;
        i_halted = 1'b0;   // only checked at start
        chk({tag, " busy after start"}, 64'(o_busy), 1);
        tick();
        chk({tag, " valid low at edge 2"}, 64'(o_tx_valid), 0);
        tick();
        chk({tag, " valid high at edge 3"}, 64'(o_tx_valid), 1);
        for (int i = 0; i < 3000 && done_cnt == d0; i++) begin
            i_start = extra_start && (i % 37 == 5) && !o_done;
            tick();
        end
        i_start  = 1'b0;
        i_halted = 1'b1;
        chk({tag, " done seen"}, 64'(done_cnt != d0), 1);
        tick();
        tick();
        chk({tag, " done pulses"}, 64'(done_cnt - d0), 1);
        chk({tag, " idle after done"}, 64'(o_busy), 0);

        for (int k = 0; k < NREG; k++)
            for (int b = 0; b < NBYTES; b++)
                exp_q.push_back(NB_BYTE'(rf[k] >> (NB_BYTE * b)));
        chk({tag, " byte count"}, 64'(got_q.size()), 64'(exp_q.size()));
        nbad = 0;
        first_bad = -1;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            if (got_q[i] !== exp_q[i]) begin
                nbad++;
                if (first_bad < 0) first_bad = i;
            end
        chk({tag, " bad bytes"}, 64'(nbad), 0);
        if (first_bad >= 0)
            chk({tag, " first bad byte"}, 64'(got_q[first_bad]), 64'(exp_q[first_bad]));

        chk({tag, " read count"}, 64'(addr_q.size()), NREG);
        nbad = 0;
        for (int k = 0; k < addr_q.size(); k++)
            if (addr_q[k] != k) nbad++;
        chk({tag, " read addr sequence"}, 64'(nbad), 0);
        if (chk_time && rdcyc_q.size() > 0)
            chk({tag, " READ->DONE cycles"}, 64'(done_cyc - rdcyc_q[0]), 64'(NREG * (2 + NBYTES)));
    endtask

    initial begin
        int bad;
        int d0;
        for (int k = 0; k < NREG; k++) rf[k] = 32'hA0B0C0D0 + k;

        // Reset
        i_rst = 1'b1;
        tick(); tick(); tick();
        chk_idle("reset");
        i_rst = 1'b0;
        tick();
        chk_idle("post-reset idle");

        // Full dump, no backpressure
        rnd_ready = 1'b0;
        do_dump("plain", 1'b0, 1'b1);
        if (got_q.size() == NREG * NBYTES) begin
            chk("first byte 0", 64'(got_q[0]), 64'hD0);
            chk("first byte 1", 64'(got_q[1]), 64'hC0);
            chk("first byte 2", 64'(got_q[2]), 64'hB0);
            chk("first byte 3", 64'(got_q[3]), 64'hA0);
            chk("last byte 0", 64'(got_q[124]), 64'hEF);
            chk("last byte 1", 64'(got_q[125]), 64'hC0);
            chk("last byte 2", 64'(got_q[126]), 64'hB0);
            chk("last byte 3", 64'(got_q[127]), 64'hA0);
        end

        // Start without halt is ignored
        i_halted = 1'b0;
        i_start  = 1'b1;
        tick();
        i_start  = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (o_busy || o_tx_valid || o_rf_sel) bad++;
            tick();
        end
        i_halted = 1'b1;
        chk("not halted stays idle", 64'(bad), 0);

        // Random backpressure with extra start pulses while busy
        rnd_ready = 1'b1;
        do_dump("backpressure", 1'b1, 1'b0);
        chk("stall stability", 64'(stall_err), 0);
        rnd_ready = 1'b0;
        tick();

        // Abort during the second byte of r[3]
        got_q.delete();
        d0 = done_cnt;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        bad = 1;
        for (int i = 0; i < 200 && bad != 0; i++) begin
            if (o_tx_valid && o_rf_rd_addr == 3 && got_q.size() == 3 * NBYTES + 1) bad = 0;
            else tick();
        end
        chk("abort point reached", 64'(bad), 0);
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        chk("abort busy", 64'(o_busy), 0);
        chk("abort tx_valid", 64'(o_tx_valid), 0);
        chk("abort rf_sel", 64'(o_rf_sel), 0);
        tick(); tick(); tick();
        chk("abort no done", 64'(done_cnt - d0), 0);
        do_dump("after abort", 1'b0, 1'b1);

        // Reset mid-dump at r[10]
        d0 = done_cnt;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        bad = 1;
        for (int i = 0; i < 200 && bad != 0; i++) begin
            if (o_rf_sel && o_rf_rd_addr == 10) bad = 0;
            else tick();
        end
        chk("reset point reached", 64'(bad), 0);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        chk_idle("mid-dump reset");
        tick(); tick();
        chk("reset no done", 64'(done_cnt - d0), 0);
        do_dump("after reset", 1'b0, 1'b1);

        // Random register contents under backpressure
        for (int k = 0; k < NREG; k++) rf[k] = $urandom;
        rnd_ready = 1'b1;
        do_dump("random data", 1'b0, 1'b0);
        rnd_ready = 1'b0;
        tick();

        chk("final stall stability", 64'(stall_err), 0);
        chk("rf_sel only when owning", 64'(sel_err), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_dump_ctrl.md
Name: regfile_dump_ctrl

Overview:
- Debug-side controller that sequences read port 1 of the MIPS register file while the pipeline is halted.
- Reads every architectural register in turn, from 0 to 2**NB_ADDR-1.
- Streams each word to the debug unit's UART transmitter as bytes, least-significant byte first, over a valid/ready handshake.
- Sits between the debug unit (start/abort, tx byte stream) and the register-file read-address mux.

Parameters:
- NB_DATA, 32: register width in bits; must be a multiple of NB_BYTE.
- NB_ADDR, 5: register address width; the block dumps 2**NB_ADDR registers.
- NB_BYTE, 8: width of one transmitted byte.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- i_rst  input  1  synchronous reset, active-high.
- i_start  input  1  dump request, sampled in IDLE only.
- i_abort  input  1  cancel an in-progress dump.
- i_halted  input  1  pipeline halted; a dump starts only when this is 1.
- o_rf_sel  output  1  1 = this block owns register-file read address 1.
- o_rf_rd_addr  output  NB_ADDR  register-file read address 1.
- i_rf_rd_data  input  NB_DATA  register-file read data 1; registered, valid one cycle after the address.
- o_tx_valid  output  1  byte available.
- o_tx_data  output  NB_BYTE  byte to transmit.
- i_tx_ready  input  1  transmitter accepts the byte.
- o_busy  output  1  dump in progress (any state except IDLE).
- o_done  output  1  one-cycle pulse after the last byte is accepted.

Behaviour:
- Reset is synchronous and active-high. While i_rst=1 the block goes to IDLE and holds:
  - o_rf_sel=0, o_rf_rd_addr=0
  - o_tx_valid=0, o_tx_data=0
  - o_busy=0, o_done=0
  - internal reg_idx=0, byte_idx=0, word=0
- Reset mid-dump: the block returns to IDLE with no done pulse; a later dump restarts from register 0.
- State machine: IDLE, READ, LATCH, SEND, DONE.
  - IDLE: if i_start=1 and i_halted=1, set reg_idx=0 and go to READ. If i_start=1 and i_halted=0, ignore it and stay in IDLE.
  - READ: o_rf_sel=1, o_rf_rd_addr=reg_idx. Go to LATCH next cycle.
  - LATCH: o_rf_sel=1, address held. Capture i_rf_rd_data into word, set byte_idx=0, go to SEND.
  - SEND: o_tx_valid=1, o_tx_data=word[NB_BYTE*byte_idx +: NB_BYTE]. On the cycle with o_tx_valid=1 and i_tx_ready=1:
    - if byte_idx < NB_DATA/NB_BYTE-1: byte_idx increments.
    - else if reg_idx = 2**NB_ADDR-1: go to DONE.
    - else reg_idx increments and the block goes to READ.
  - DONE: o_done=1 for exactly one cycle, then IDLE.
- Handshake rules:
  - While o_tx_valid=1 and i_tx_ready=0, o_tx_data, byte_idx and reg_idx hold.
  - o_tx_valid never drops without a transfer, except on abort or reset.
  - i_tx_ready is ignored outside SEND.
- Latency:
  - o_tx_valid first rises after the 3rd rising edge, counting the edge that samples i_start.
  - With i_tx_ready tied to 1, each register costs 2 + NB_DATA/NB_BYTE cycles (6 at defaults).
  - A full dump takes 192 cycles from the first READ to the DONE cycle at defaults; o_done follows the final transfer edge.
- Abort: i_abort=1 in any non-IDLE state sends the block to IDLE on the next edge, with o_tx_valid=0, o_rf_sel=0 and no o_done. i_abort in IDLE has no effect.
- Priority: i_rst > i_abort > all other transitions.
- i_start while busy is ignored. i_halted is checked only at start; a deassertion mid-dump does not stop the dump.
- Arithmetic and widths:
  - reg_idx is NB_ADDR bits; its terminal check is against all-ones, so it never wraps.
  - byte_idx is clog2(NB_DATA/NB_BYTE) bits.
- o_rf_sel is combinational from the state: 1 only in READ, LATCH and SEND. In IDLE, o_rf_rd_addr=0.

Test Plan:
- Register r[k]=32'hA0B0C0D0+k, i_halted=1, pulse i_start, i_tx_ready=1:
  - 128 bytes arrive; the first four are D0,C0,B0,A0 and the last four are EF,C0,B0,A0.
  - o_done pulses once, exactly 192 cycles after the first READ cycle.
- Pulse i_start with i_halted=0: o_busy, o_tx_valid and o_rf_sel stay 0 for 20 cycles.
- Random i_tx_ready backpressure (50% duty):
  - byte sequence identical to the first test;
  - o_tx_data stable on every stalled cycle;
  - no byte duplicated or dropped.
- i_abort during the second byte of r[3]:
  - next cycle o_busy=0, o_tx_valid=0, no o_done;
  - a new start dumps from r[0] again.
- i_rst=1 for one cycle mid-dump at r[10]: all outputs return to reset values on the next edge; the following dump is complete and correct.
- Check the o_rf_rd_addr sequence at READ: 0,1,...,31 with no wrap to 0 after 31. o_rf_sel=1 only in READ, LATCH and SEND. Extra i_start pulses while busy do not restart the dump.
